pic_bus_master: RTL and testbench
=================================

// Module: pic_bus_master
// PURPOSE
//  CPU-side bus initiator for the 8259A PIC read/write port. Turns single-cycle
//  requests into timed CS_n/WR_n/RD_n/A0/D bus cycles toward the PIC.
//  Supports init (ICW1, ICW2, then optional ICW3 and ICW4), OCW1-3 writes and
//  status reads (IRR/ISR/IMR). Sits between the test host/CPU model and the PIC.
// PARAMETERS
//  SETUP_CYC  1  cycles of CS_n low with A0/D valid before the strobe (1..15)
//  PULSE_CYC  2  cycles WR_n/RD_n held low (1..15)
//  HOLD_CYC   1  cycles after the strobe rises with CS_n/A0/D held (1..15)
// PORTS
//  clk       in   1  system clock, rising edge
//  reset     in   1  asynchronous, active-high
//  init_req  in   1  start the ICW sequence (1-cycle pulse)
//  icw1..4   in   8  ICW bytes, sampled at init_req
//  op_req    in   1  start one OCW write or one read (1-cycle pulse)
//  op_sel    in   2  00 OCW1, 01 OCW2, 10 OCW3, 11 read
//  op_data   in   8  OCW byte, sampled at op_req
//  rd_a0     in   1  A0 for read (1 = IMR; 0 = IRR/ISR as set by prior OCW3)
//  busy      out  1  sequence in progress
//  done      out  1  1-cycle pulse when a sequence/op completes
//  rd_data   out  8  last read byte; holds until next read
//  rd_valid  out  1  1-cycle pulse with done for reads
//  err       out  1  1-cycle pulse: request rejected
//  inited    out  1  ICW sequence completed since reset
//  cs_n, wr_n, rd_n  out 1  PIC strobes, active low
//  a0        out  1  PIC address line
//  d_out     out  8  write data; d_oe out 1 drive enable; d_in in 8 read data
// BEHAVIOUR
//  Reset (async): cs_n=wr_n=rd_n=1, a0=0, d_out=0, d_oe=0, busy=done=err=0,
//   rd_data=0, rd_valid=0, inited=0, FSM=IDLE. Mid-cycle reset releases the bus
//   at once; the PIC sees an aborted cycle and no strobe edge follows.
//  FSM: IDLE -> SETUP -> STROBE -> HOLD -> RECOV -> (next access: SETUP | IDLE).
//  All bus outputs registered. Request accepted on edge t: busy=1 and cs_n=0
//   from t+1. SETUP: cs_n=0, a0/d_out valid, d_oe=1 for writes, 0 for reads.
//   STROBE: wr_n or rd_n =0 for PULSE_CYC. HOLD: strobe=1, cs_n/a0/d held.
//   RECOV: 1 cycle, cs_n=1, d_oe=0. Access = SETUP+PULSE+HOLD+1 cycles (5 default).
//  Read: d_in captured into rd_data on the last STROBE cycle.
//  Init list fixed at init_req: ICW1 (a0=0, bit4 forced 1), ICW2 (a0=1);
//   ICW3 (a0=1) only if icw1[1]=0; ICW4 (a0=1) only if icw1[0]=1. Accesses run
//   back-to-back; inited=0 at acceptance, 1 with done after the final access.
//  OCW encoding: OCW1 a0=1 byte as-is; OCW2 a0=0 bits[4:3] forced 00;
//   OCW3 a0=0 bit7=0, bits[4:3]=01 forced. Read a0=rd_a0.
//  done (and rd_valid for reads) pulse the cycle after the last RECOV; busy=0
//   in that same cycle; a new request is accepted in that cycle.
//  Rejects (err pulse next cycle, no bus activity): any request while busy;
//   op_req with inited=0; init_req and op_req together -> init accepted, op
//   rejected. init_req while inited=1 is a valid re-init.
// TESTING
//  T1 reset mid-STROBE of a write -> wr_n=1, cs_n=1, d_oe=0 same cycle, inited=0.
//  T2 init icw1=8'h11 (cascade, IC4), icw2=8'h20, icw3=8'h04, icw4=8'h01 ->
//     4 accesses a0/d = 0/11, 1/20, 1/04, 1/01; done at 21st cycle; inited=1.
//  T3 init icw1=8'h13 (single, IC4) -> 3 accesses, no ICW3; icw1=8'h02 -> 2 accesses.
//  T4 OCW2 op_data=8'hFF -> a0=0, d=8'hE7; OCW3 8'h8B -> a0=0, d=8'h0B.
//  T5 read rd_a0=1, PIC model drives d_in=8'h5A only while rd_n=0 ->
//     rd_data=8'h5A, rd_valid with done, d_oe=0 throughout.
//  T6 op_req before init, op_req while busy, init+op same edge -> err each,
//     bus idle for rejected ones; PULSE_CYC=4 run repeats T2 with 7-cycle access.

Source files
------------

// File: rtl/pic_bus_master.sv
// CPU-side bus initiator for an 8259A PIC: turns single-cycle init/op requests
// into registered CS_n/WR_n/RD_n/A0/D cycles with programmable setup/pulse/hold.
module pic_bus_master #(
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 2,
    parameter int HOLD_CYC  = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       init_req,
    input  logic [7:0] icw1,
    input  logic [7:0] icw2,
    input  logic [7:0] icw3,
    input  logic [7:0] icw4,
    input  logic       op_req,
    input  logic [1:0] op_sel,
    input  logic [7:0] op_data,
    input  logic       rd_a0,
    output logic       busy,
    output logic       done,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       err,
    output logic       inited,
    output logic       cs_n,
    output logic       wr_n,
    output logic       rd_n,
    output logic       a0,
    output logic [7:0] d_out,
    output logic       d_oe,
    input  logic [7:0] d_in
);

    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, RECOV} state_t;

    localparam logic [3:0] SETUP_LAST = 4'(SETUP_CYC - 1);
    localparam logic [3:0] PULSE_LAST = 4'(PULSE_CYC - 1);
    localparam logic [3:0] HOLD_LAST  = 4'(HOLD_CYC - 1);

    state_t          state_reg, state_next;
    logic [3:0]      cnt_reg, cnt_next;
    logic [1:0]      idx_reg, idx_next;
    logic [2:0]      len_reg, len_next;
    logic            is_read_reg, is_read_next;
    logic            is_init_reg, is_init_next;
    logic [3:0]      seq_a0_reg, seq_a0_next;
    logic [3:0][7:0] seq_d_reg, seq_d_next;

    logic       busy_reg, busy_next;
    logic       done_reg, done_next;
    logic [7:0] rd_data_reg, rd_data_next;
    logic       rd_valid_reg, rd_valid_next;
    logic       err_reg, err_next;
    logic       inited_reg, inited_next;
    logic       cs_n_reg, cs_n_next;
    logic       wr_n_reg, wr_n_next;
    logic       rd_n_reg, rd_n_next;
    logic       a0_reg, a0_next;
    logic [7:0] d_out_reg, d_out_next;
    logic       d_oe_reg, d_oe_next;

    logic            load;
    logic            ld_a0;
    logic [7:0]      ld_d;
    logic            ld_rd;
    logic [3:0][7:0] init_d;
    logic [2:0]      init_len;
    logic            op_a0;
    logic [7:0]      op_byte;

    // Init list is packed densely: ICW3/ICW4 slide down when ICW3 is skipped.
    always_comb begin
        init_d    = '0;
        init_d[0] = icw1 | 8'h10;
        init_d[1] = icw2;
        init_len  = 3'd2;
        if (!icw1[1]) begin
            init_d[init_len[1:0]] = icw3;
            init_len = init_len + 3'd1;
        end
        if (icw1[0]) begin
            init_d[init_len[1:0]] = icw4;
            init_len = init_len + 3'd1;
        end
    end

    always_comb begin
        op_a0   = 1'b0;
        op_byte = op_data;
        case (op_sel)
            2'b00:   op_a0 = 1'b1;
            2'b01:   op_byte = {op_data[7:5], 2'b00, op_data[2:0]};
            2'b10:   op_byte = {1'b0, op_data[6:5], 2'b01, op_data[2:0]};
            default: op_a0 = rd_a0;
        endcase
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        idx_next      = idx_reg;
        len_next      = len_reg;
        is_read_next  = is_read_reg;
        is_init_next  = is_init_reg;
        seq_a0_next   = seq_a0_reg;
        seq_d_next    = seq_d_reg;
        busy_next     = busy_reg;
        done_next     = 1'b0;
        rd_data_next  = rd_data_reg;
        rd_valid_next = 1'b0;
        err_next      = 1'b0;
        inited_next   = inited_reg;
        cs_n_next     = cs_n_reg;
        wr_n_next     = wr_n_reg;
        rd_n_next     = rd_n_reg;
        a0_next       = a0_reg;
        d_out_next    = d_out_reg;
        d_oe_next     = d_oe_reg;
        load          = 1'b0;
        ld_a0         = 1'b0;
        ld_d          = '0;
        ld_rd         = 1'b0;

        case (state_reg)
            IDLE: begin
                if (init_req) begin
                    load         = 1'b1;
                    ld_d         = init_d[0];
                    seq_a0_next  = 4'b1110;
                    seq_d_next   = init_d;
                    len_next     = init_len;
                    idx_next     = 2'd0;
                    is_read_next = 1'b0;
                    is_init_next = 1'b1;
                    inited_next  = 1'b0;
                    err_next     = op_req;
                end else if (op_req) begin
                    if (!inited_reg) begin
                        err_next = 1'b1;
                    end else begin
                        load          = 1'b1;
                        ld_a0         = op_a0;
                        ld_d          = op_byte;
                        ld_rd         = (op_sel == 2'b11);
                        seq_a0_next   = {3'b000, op_a0};
                        seq_d_next    = '0;
                        seq_d_next[0] = op_byte;
                        len_next      = 3'd1;
                        idx_next      = 2'd0;
                        is_read_next  = (op_sel == 2'b11);
                        is_init_next  = 1'b0;
                    end
                end
            end
            SETUP: begin
                if (cnt_reg == SETUP_LAST) begin
                    state_next = STROBE;
                    cnt_next   = '0;
                    if (is_read_reg) rd_n_next = 1'b0;
                    else             wr_n_next = 1'b0;
                end else begin
                    cnt_next = cnt_reg + 4'd1;
                end
            end
            STROBE: begin
                if (cnt_reg == PULSE_LAST) begin
                    state_next = HOLD;
                    cnt_next   = '0;
                    wr_n_next  = 1'b1;
                    rd_n_next  = 1'b1;
                    // rd_n is still low this cycle, so the PIC is driving d_in.
                    if (is_read_reg) rd_data_next = d_in;
                end else begin
                    cnt_next = cnt_reg + 4'd1;
                end
            end
            HOLD: begin
                if (cnt_reg == HOLD_LAST) begin
                    state_next = RECOV;
                    cnt_next   = '0;
                    cs_n_next  = 1'b1;
                    d_oe_next  = 1'b0;
                end else begin
                    cnt_next = cnt_reg + 4'd1;
                end
            end
            RECOV: begin
                if (({1'b0, idx_reg} + 3'd1) < len_reg) begin
                    idx_next = idx_reg + 2'd1;
                    load     = 1'b1;
                    ld_a0    = seq_a0_reg[idx_next];
                    ld_d     = seq_d_reg[idx_next];
                    ld_rd    = is_read_reg;
                end else begin
                    state_next    = IDLE;
                    busy_next     = 1'b0;
                    done_next     = 1'b1;
                    rd_valid_next = is_read_reg;
                    if (is_init_reg) inited_next = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        if (state_reg != IDLE && (init_req || op_req)) err_next = 1'b1;

        if (load) begin
            state_next = SETUP;
            cnt_next   = '0;
            busy_next  = 1'b1;
            cs_n_next  = 1'b0;
            a0_next    = ld_a0;
            d_oe_next  = !ld_rd;
            if (!ld_rd) d_out_next = ld_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            idx_reg      <= '0;
            len_reg      <= '0;
            is_read_reg  <= 1'b0;
            is_init_reg  <= 1'b0;
            seq_a0_reg   <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            rd_data_reg  <= '0;
            rd_valid_reg <= 1'b0;
            err_reg      <= 1'b0;
            inited_reg   <= 1'b0;
            cs_n_reg     <= 1'b1;
            wr_n_reg     <= 1'b1;
            rd_n_reg     <= 1'b1;
            a0_reg       <= 1'b0;
            d_out_reg    <= '0;
            d_oe_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            idx_reg      <= idx_next;
            len_reg      <= len_next;
            is_read_reg  <= is_read_next;
            is_init_reg  <= is_init_next;
            seq_a0_reg   <= seq_a0_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
            rd_data_reg  <= rd_data_next;
            rd_valid_reg <= rd_valid_next;
            err_reg      <= err_next;
            inited_reg   <= inited_next;
            cs_n_reg     <= cs_n_next;
            wr_n_reg     <= wr_n_next;
            rd_n_reg     <= rd_n_next;
            a0_reg       <= a0_next;
            d_out_reg    <= d_out_next;
            d_oe_reg     <= d_oe_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_seq
            always_ff @(posedge clk or posedge reset) begin
                if (reset) seq_d_reg[gi] <= '0;
                else       seq_d_reg[gi] <= seq_d_next[gi];
            end
        end
    endgenerate

    assign busy     = busy_reg;
    assign done     = done_reg;
    assign rd_data  = rd_data_reg;
    assign rd_valid = rd_valid_reg;
    assign err      = err_reg;
    assign inited   = inited_reg;
    assign cs_n     = cs_n_reg;
    assign wr_n     = wr_n_reg;
    assign rd_n     = rd_n_reg;
    assign a0       = a0_reg;
    assign d_out    = d_out_reg;
    assign d_oe     = d_oe_reg;

endmodule

// File: tb/tb_pic_bus_master.sv
// Self-checking bench for pic_bus_master: bus monitor + queue-based reference
// model of the expected access list and completion timing.
module tb_pic_bus_master;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       req_init, req_op, sel4;
    logic [7:0] icw1, icw2, icw3, icw4, op_data, pic_val;
    logic [1:0] op_sel;
    logic       rd_a0;

    logic       init_req, op_req, init_req4, op_req4;
    logic [7:0] d_in, d_in4;

    logic       busy, done, rd_valid, err, inited, cs_n, wr_n, rd_n, a0, d_oe;
    logic [7:0] rd_data, d_out;
    logic       busy4, done4, rd_valid4, err4, inited4, cs_n4, wr_n4, rd_n4, a04, d_oe4;
    logic [7:0] rd_data4, d_out4;

    assign init_req  = sel4 ? 1'b0 : req_init;
    assign op_req    = sel4 ? 1'b0 : req_op;
    assign init_req4 = sel4 ? req_init : 1'b0;
    assign op_req4   = sel4 ? req_op : 1'b0;
    // PIC model: drives the data bus only while its RD_n is low.
    assign d_in  = (rd_n === 1'b0)  ? pic_val : 8'h00;
    assign d_in4 = (rd_n4 === 1'b0) ? pic_val : 8'h00;

    pic_bus_master dut (
        .clk(clk), .reset(reset), .init_req(init_req),
        .icw1(icw1), .icw2(icw2), .icw3(icw3), .icw4(icw4),
        .op_req(op_req), .op_sel(op_sel), .op_data(op_data), .rd_a0(rd_a0),
        .busy(busy), .done(done), .rd_data(rd_data), .rd_valid(rd_valid),
        .err(err), .inited(inited), .cs_n(cs_n), .wr_n(wr_n), .rd_n(rd_n),
        .a0(a0), .d_out(d_out), .d_oe(d_oe), .d_in(d_in)
    );

    pic_bus_master #(.SETUP_CYC(1), .PULSE_CYC(4), .HOLD_CYC(1)) dut4 (
        .clk(clk), .reset(reset), .init_req(init_req4),
        .icw1(icw1), .icw2(icw2), .icw3(icw3), .icw4(icw4),
        .op_req(op_req4), .op_sel(op_sel), .op_data(op_data), .rd_a0(rd_a0),
        .busy(busy4), .done(done4), .rd_data(rd_data4), .rd_valid(rd_valid4),
        .err(err4), .inited(inited4), .cs_n(cs_n4), .wr_n(wr_n4), .rd_n(rd_n4),
        .a0(a04), .d_out(d_out4), .d_oe(d_oe4), .d_in(d_in4)
    );

    logic       m_busy, m_done, m_rd_valid, m_err, m_inited, m_cs_n, m_wr_n, m_rd_n, m_a0, m_d_oe;
    logic [7:0] m_rd_data, m_d_out;
    assign m_busy     = sel4 ? busy4 : busy;
    assign m_done     = sel4 ? done4 : done;
    assign m_rd_valid = sel4 ? rd_valid4 : rd_valid;
    assign m_err      = sel4 ? err4 : err;
    assign m_inited   = sel4 ? inited4 : inited;
    assign m_cs_n     = sel4 ? cs_n4 : cs_n;
    assign m_wr_n     = sel4 ? wr_n4 : wr_n;
    assign m_rd_n     = sel4 ? rd_n4 : rd_n;
    assign m_a0       = sel4 ? a04 : a0;
    assign m_d_oe     = sel4 ? d_oe4 : d_oe;
    assign m_rd_data  = sel4 ? rd_data4 : rd_data;
    assign m_d_out    = sel4 ? d_out4 : d_out;

    typedef struct {
        logic       a0;
        logic [7:0] d;
        bit         rd;
        int         su;
        int         pu;
        int         ho;
        int         oe_on;
        bit         a0_ok;
        bit         d_ok;
    } acc_t;

    acc_t acc_q[$];
    acc_t cur;
    bit   in_acc;

    int         errors, checks;
    logic       exp_a0[$];
    logic [7:0] exp_d[$];
    bit         exp_rd;
    logic [7:0] exp_rdata;
    logic [7:0] last_rd [2];

    // Bus monitor: one record per CS_n-low window, phases measured in cycles.
    always @(negedge clk) begin
        if (reset) begin
            in_acc = 1'b0;
        end else if (m_cs_n === 1'b0) begin
            if (!in_acc) begin
                in_acc = 1'b1;
                cur.a0 = m_a0; cur.d = m_d_out; cur.rd = 1'b0;
                cur.su = 0; cur.pu = 0; cur.ho = 0; cur.oe_on = 0;
                cur.a0_ok = 1'b1; cur.d_ok = 1'b1;
            end
            if (m_a0 !== cur.a0) cur.a0_ok = 1'b0;
            if (m_d_out !== cur.d) cur.d_ok = 1'b0;
            if (m_d_oe === 1'b1) cur.oe_on++;
            if (m_rd_n === 1'b0) begin cur.rd = 1'b1; cur.pu++; end
            else if (m_wr_n === 1'b0) cur.pu++;
            else if (cur.pu == 0) cur.su++;
            else cur.ho++;
        end else if (in_acc) begin
            acc_q.push_back(cur);
            in_acc = 1'b0;
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        #1 reset = 1'b0;
        last_rd[0] = 8'h00;
        last_rd[1] = 8'h00;
        @(negedge clk);
    endtask

    task automatic model_init(input logic [7:0] i1, input logic [7:0] i2,
                              input logic [7:0] i3, input logic [7:0] i4);
        exp_a0.delete(); exp_d.delete(); exp_rd = 1'b0;
        exp_a0.push_back(1'b0); exp_d.push_back(i1 | 8'h10);
        exp_a0.push_back(1'b1); exp_d.push_back(i2);
        if (i1[1] == 1'b0) begin exp_a0.push_back(1'b1); exp_d.push_back(i3); end
        if (i1[0] == 1'b1) begin exp_a0.push_back(1'b1); exp_d.push_back(i4); end
    endtask

    task automatic run_seq(input bit is_init, input bit also_op, input int op_at, input string name);
        int  n, k, pw, acc;
        bit  seen;
        n   = exp_d.size();
        pw  = sel4 ? 4 : 2;
        acc = 1 + pw + 1 + 1;
        acc_q.delete();
        if (is_init) req_init = 1'b1; else req_op = 1'b1;
        if (also_op) req_op = 1'b1;
        @(negedge clk);
        req_init = 1'b0; req_op = 1'b0;
        checks++;
        if (m_busy !== 1'b1 || m_cs_n !== 1'b0 || m_err !== also_op) begin
            errors++;
            $display("FAIL %s_start: busy/cs_n/err=%b%b%b expected 10%b", name, m_busy, m_cs_n, m_err, also_op);
        end
        if (is_init) begin
            checks++;
            if (m_inited !== 1'b0) begin errors++; $display("FAIL %s_inited_clear: inited=%b expected 0", name, m_inited); end
        end
        k = 1; seen = 1'b0;
        while (!seen && k < 400) begin
            if (m_done === 1'b1) seen = 1'b1;
            else begin
                if (k == op_at) req_op = 1'b1;
                @(negedge clk);
                k++;
                if (op_at > 0 && k == op_at + 1) begin
                    req_op = 1'b0;
                    checks++;
                    if (m_err !== 1'b1) begin errors++; $display("FAIL %s_busy_reject: err=%b expected 1", name, m_err); end
                end
            end
        end
        checks++;
        if (!seen || k != n * acc + 1) begin
            errors++;
            $display("FAIL %s_done_cycle: done seen=%0d at cycle %0d expected cycle %0d", name, seen, k, n * acc + 1);
        end
        if (seen) begin
            checks++;
            if (m_busy !== 1'b0 || m_rd_valid !== exp_rd) begin
                errors++;
                $display("FAIL %s_done_flags: busy=%b rd_valid=%b expected 0 %b", name, m_busy, m_rd_valid, exp_rd);
            end
            if (is_init) begin
                checks++;
                if (m_inited !== 1'b1) begin errors++; $display("FAIL %s_inited_set: inited=%b expected 1", name, m_inited); end
            end
            if (exp_rd) last_rd[sel4] = exp_rdata;
            checks++;
            if (m_rd_data !== last_rd[sel4]) begin
                errors++;
                $display("FAIL %s_rd_data: rd_data=%h expected %h", name, m_rd_data, last_rd[sel4]);
            end
        end
        checks++;
        if (acc_q.size() != n) begin
            errors++;
            $display("FAIL %s_access_count: got %0d accesses expected %0d", name, acc_q.size(), n);
        end
        for (int i = 0; i < n && i < acc_q.size(); i++) begin
            checks++;
            if (acc_q[i].a0 !== exp_a0[i] || (!exp_rd && acc_q[i].d !== exp_d[i]) ||
                acc_q[i].rd != exp_rd || acc_q[i].su != 1 || acc_q[i].pu != pw || acc_q[i].ho != 1 ||
                !acc_q[i].a0_ok || (!exp_rd && !acc_q[i].d_ok) ||
                acc_q[i].oe_on != (exp_rd ? 0 : 2 + pw)) begin
                errors++;
                $display("FAIL %s_access%0d: a0=%b d=%h rd=%0d su/pu/ho=%0d/%0d/%0d oe=%0d stable=%0d%0d expected a0=%b d=%h rd=%0d 1/%0d/1 oe=%0d",
                         name, i, acc_q[i].a0, acc_q[i].d, acc_q[i].rd, acc_q[i].su, acc_q[i].pu, acc_q[i].ho,
                         acc_q[i].oe_on, acc_q[i].a0_ok, acc_q[i].d_ok, exp_a0[i], exp_d[i], exp_rd, pw,
                         exp_rd ? 0 : 2 + pw);
            end
        end
        $display("txn %s: accesses=%0d done_cycle=%0d rd_data=%h", name, acc_q.size(), k, m_rd_data);
    endtask

    task automatic run_init(input logic [7:0] i1, input logic [7:0] i2, input logic [7:0] i3,
                            input logic [7:0] i4, input bit also_op, input int op_at);
        icw1 = i1; icw2 = i2; icw3 = i3; icw4 = i4;
        model_init(i1, i2, i3, i4);
        run_seq(1'b1, also_op, op_at, "init");
    endtask

    task automatic run_op(input logic [1:0] sel, input logic [7:0] data, input logic ra0);
        op_sel = sel; op_data = data; rd_a0 = ra0;
        exp_a0.delete(); exp_d.delete();
        exp_rd = (sel == 2'b11);
        exp_rdata = pic_val;
        case (sel)
            2'b00:   begin exp_a0.push_back(1'b1); exp_d.push_back(data); end
            2'b01:   begin exp_a0.push_back(1'b0); exp_d.push_back(data & 8'hE7); end
            2'b10:   begin exp_a0.push_back(1'b0); exp_d.push_back((data & 8'h67) | 8'h08); end
            default: begin exp_a0.push_back(ra0);  exp_d.push_back(8'h00); end
        endcase
        run_seq(1'b0, 1'b0, 0, exp_rd ? "read" : "ocw");
    endtask

    task automatic test_reset();
        checks++;
        if ({cs_n, wr_n, rd_n, a0, d_oe, busy, done, err, rd_valid, inited} !== 10'b1110000000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 1110000000",
                     {cs_n, wr_n, rd_n, a0, d_oe, busy, done, err, rd_valid, inited});
        end
        checks++;
        if (d_out !== 8'h00 || rd_data !== 8'h00) begin
            errors++; $display("FAIL reset_data: d_out=%h rd_data=%h expected 00 00", d_out, rd_data);
        end
        checks++;
        if ({cs_n4, wr_n4, rd_n4, busy4, inited4} !== 5'b11100) begin
            errors++; $display("FAIL reset_dut4: got %b expected 11100", {cs_n4, wr_n4, rd_n4, busy4, inited4});
        end
        $display("txn reset: checked idle outputs");
    endtask

    task automatic test_reject_uninit();
        acc_q.delete();
        op_sel = 2'b00; op_data = 8'h3C;
        req_op = 1'b1;
        @(negedge clk);
        req_op = 1'b0;
        checks++;
        if (err !== 1'b1 || busy !== 1'b0 || cs_n !== 1'b1) begin
            errors++; $display("FAIL uninit_reject: err/busy/cs_n=%b%b%b expected 101", err, busy, cs_n);
        end
        @(negedge clk);
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL uninit_err_pulse: err=%b expected 0", err); end
        repeat (6) @(negedge clk);
        checks++;
        if (acc_q.size() != 0) begin
            errors++; $display("FAIL uninit_bus_idle: got %0d accesses expected 0", acc_q.size());
        end
        $display("txn op before init rejected");
    endtask

    task automatic test_init_fixed();
        run_init(8'h11, 8'h20, 8'h04, 8'h01, 1'b0, 0);
        run_init(8'h13, 8'h28, 8'h00, 8'h03, 1'b0, 0);
        run_init(8'h02, 8'h40, 8'h77, 8'h55, 1'b0, 0);
    endtask

    task automatic test_init_random();
        for (int i = 0; i < 6; i++)
            run_init(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b0, 0);
        run_init(8'h11, 8'h20, 8'h04, 8'h01, 1'b0, 0);
    endtask

    task automatic test_ocw();
        run_op(2'b01, 8'hFF, 1'b0);
        run_op(2'b10, 8'h8B, 1'b0);
        for (int i = 0; i < 10; i++) begin
            pic_val = 8'($urandom_range(1, 255));
            run_op(2'($urandom_range(0, 3)), 8'($urandom), 1'($urandom));
        end
    endtask

    task automatic test_read();
        pic_val = 8'h5A;
        run_op(2'b11, 8'h00, 1'b1);
        pic_val = 8'hC3;
        run_op(2'b00, 8'hF0, 1'b0);
    endtask

    task automatic test_reject_busy();
        run_init(8'h11, 8'h20, 8'h04, 8'h01, 1'b1, 0);
        run_init(8'h13, 8'h08, 8'h00, 8'h01, 1'b0, 4);
    endtask

    task automatic test_back_to_back();
        pic_val = 8'h96;
        run_op(2'b11, 8'h00, 1'b0);
        run_op(2'b00, 8'hA5, 1'b0);
        run_op(2'b10, 8'h0A, 1'b0);
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || rd_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL b2b_idle: done/rd_valid/busy=%b%b%b expected 000", done, rd_valid, busy);
        end
    endtask

    task automatic test_reset_mid();
        int k;
        bit activity;
        acc_q.delete();
        op_sel = 2'b00; op_data = 8'hA5;
        req_op = 1'b1;
        @(negedge clk);
        req_op = 1'b0;
        k = 0;
        while (wr_n !== 1'b0 && k < 20) begin @(negedge clk); k++; end
        checks++;
        if (wr_n !== 1'b0) begin errors++; $display("FAIL midreset_reach_strobe: wr_n=%b expected 0", wr_n); end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({wr_n, cs_n, d_oe} !== 3'b110) begin
            errors++; $display("FAIL midreset_release: wr_n/cs_n/d_oe=%b expected 110", {wr_n, cs_n, d_oe});
        end
        checks++;
        if (inited !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL midreset_state: inited/busy=%b%b expected 00", inited, busy);
        end
        @(negedge clk);
        #1 reset = 1'b0;
        last_rd[0] = 8'h00;
        last_rd[1] = 8'h00;
        activity = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (wr_n !== 1'b1 || rd_n !== 1'b1 || cs_n !== 1'b1) activity = 1'b1;
        end
        checks++;
        if (activity || acc_q.size() != 0) begin
            errors++; $display("FAIL midreset_no_strobe: activity=%0d accesses=%0d expected 0 0", activity, acc_q.size());
        end
        $display("txn reset during strobe: bus released");
    endtask

    task automatic test_pulse4();
        sel4 = 1'b1;
        do_reset();
        run_init(8'h11, 8'h20, 8'h04, 8'h01, 1'b0, 0);
        pic_val = 8'($urandom_range(1, 255));
        run_op(2'b11, 8'h00, 1'b1);
        run_op(2'b01, 8'hFF, 1'b0);
        sel4 = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        errors = 0; checks = 0;
        reset = 1'b1; req_init = 1'b0; req_op = 1'b0; sel4 = 1'b0;
        icw1 = '0; icw2 = '0; icw3 = '0; icw4 = '0;
        op_sel = '0; op_data = '0; rd_a0 = 1'b0; pic_val = 8'h5A;
        in_acc = 1'b0;
        do_reset();
        test_reset();
        test_reject_uninit();
        test_init_fixed();
        test_init_random();
        test_ocw();
        test_read();
        test_reject_busy();
        test_back_to_back();
        test_reset_mid();
        test_pulse4();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
